// File: rtl/uart_tx_sched.sv
// uart_tx_sched: TX FIFO to serializer scheduler with XON/XOFF injection.
// Define UART_TX_SCHED_STATS_EN to build the data_cnt/ctl_cnt counters.
module uart_tx_sched #(
  parameter logic [7:0]  XON_CHAR  = 8'h11,
  parameter logic [7:0]  XOFF_CHAR = 8'h13,
  parameter int unsigned INTER_GAP = 0,
  parameter int unsigned BUSY_TMO  = 3
) (
  input  logic        clk_uart,
  input  logic        rst,
  input  logic        flow_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        remote_xoff_lvl,
  input  logic        local_pause_lvl,
  output logic        xoff_sent,
  output logic        sched_idle,
  output logic        tmo_err,
  output logic [15:0] data_cnt,
  output logic [15:0] ctl_cnt
);
  typedef enum logic [2:0] {
    IDLE, FETCH, WAITD, LOAD, ARM, DRAIN, GAP
  } state_t;
  typedef enum logic [1:0] {
    K_DATA, K_XOFF, K_XON
  } kind_t;

  localparam bit         NO_GAP   = (INTER_GAP == 0);
  localparam logic [7:0] GAP_LAST = 8'(INTER_GAP - 1);
  localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

  state_t     state, nxt;
  kind_t      kind;
  logic [7:0] cnt;
  logic       rp_m, rp_s, lp_m, lp_s, lp_d;
  logic       lp_rise, lp_fall;
  logic       xoff_pend, xon_pend;
  logic       pause, xoff_go, xon_go, data_go;
  logic       ld_xoff, ld_xon, ld_data, done;

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      {rp_m, rp_s} <= '0;
      {lp_m, lp_s, lp_d} <= '0;
    end else begin
      rp_m <= remote_xoff_lvl;
      rp_s <= rp_m;
      lp_m <= local_pause_lvl;
      lp_s <= lp_m;
      lp_d <= lp_s;
    end
  end

  assign lp_rise = lp_s & ~lp_d;
  assign lp_fall = ~lp_s & lp_d;
  assign pause   = flow_en & rp_s;
  // Redundant control chars are never sent; their flags are dropped in IDLE
  assign xoff_go = xoff_pend & ~xoff_sent;
  assign xon_go  = xon_pend & xoff_sent;
  assign data_go = ~fifo_empty & ~pause;

  assign sched_idle = (state == IDLE) & ~xoff_pend & ~xon_pend
                    & (fifo_empty | pause);

  always_comb begin
    nxt        = state;
    fifo_rd_en = 1'b0;
    tx_start   = 1'b0;
    tmo_err    = 1'b0;
    ld_xoff    = 1'b0;
    ld_xon     = 1'b0;
    ld_data    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (xoff_go) begin
          ld_xoff = 1'b1;
          nxt     = LOAD;
        end else if (xon_go) begin
          ld_xon = 1'b1;
          nxt    = LOAD;
        end else if (data_go) begin
          nxt = FETCH;
        end
      end
      FETCH: begin
        fifo_rd_en = 1'b1;
        nxt        = WAITD;
      end
      WAITD: begin
        ld_data = 1'b1;
        nxt     = LOAD;
      end
      LOAD: begin
        tx_start = 1'b1;
        nxt      = ARM;
      end
      ARM: begin
        if (tx_busy) begin
          nxt = DRAIN;
        end else if (cnt == TMO_LAST) begin
          tmo_err = 1'b1;
          nxt     = NO_GAP ? IDLE : GAP;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          done = 1'b1;
          nxt  = NO_GAP ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // tx_data is loaded on entry to LOAD so it is valid while tx_start is high
  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      kind    <= K_DATA;
      tx_data <= '0;
      cnt     <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (state == ARM || state == GAP) cnt <= cnt + 8'd1;
      if (ld_xoff) begin
        tx_data <= XOFF_CHAR;
        kind    <= K_XOFF;
      end else if (ld_xon) begin
        tx_data <= XON_CHAR;
        kind    <= K_XON;
      end else if (ld_data) begin
        tx_data <= fifo_rdata;
        kind    <= K_DATA;
      end
    end
  end

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      xoff_pend <= 1'b0;
      xon_pend  <= 1'b0;
    end else if (!flow_en) begin
      xoff_pend <= 1'b0;
      xon_pend  <= 1'b0;
    end else if (lp_rise) begin
      xoff_pend <= 1'b1;
      xon_pend  <= 1'b0;
    end else if (lp_fall) begin
      xon_pend  <= 1'b1;
      xoff_pend <= 1'b0;
    end else begin
      if (ld_xoff || (state == IDLE && xoff_pend && xoff_sent))
        xoff_pend <= 1'b0;
      if (ld_xon || (state == IDLE && xon_pend && !xoff_sent))
        xon_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) xoff_sent <= 1'b0;
    else if (!flow_en) xoff_sent <= 1'b0;
    else if (done && kind == K_XOFF) xoff_sent <= 1'b1;
    else if (done && kind == K_XON) xoff_sent <= 1'b0;
  end

`ifdef UART_TX_SCHED_STATS_EN
  logic [15:0] dcnt, ccnt;

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      dcnt <= '0;
      ccnt <= '0;
    end else if (done) begin
      if (kind == K_DATA) begin
        if (dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
      end else begin
        if (ccnt != 16'hFFFF) ccnt <= ccnt + 16'd1;
      end
    end
  end

  assign data_cnt = dcnt;
  assign ctl_cnt  = ccnt;
`else
  assign data_cnt = 16'h0;
  assign ctl_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched.
// FIFO and serializer models plus a byte-stream scoreboard.
module tb_uart_tx_sched;
  localparam int GAP = 4;
  localparam int TMO = 3;

  logic        clk_uart = 1'b0;
  logic        rst = 1'b0;
  logic        flow_en = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = 8'h0;
  logic        fifo_rd_en;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        remote_xoff_lvl = 1'b0;
  logic        local_pause_lvl = 1'b0;
  logic        xoff_sent;
  logic        sched_idle;
  logic        tmo_err;
  logic [15:0] data_cnt;
  logic [15:0] ctl_cnt;

  always #5 clk_uart = ~clk_uart;

  uart_tx_sched #(
    .XON_CHAR (8'h11),
    .XOFF_CHAR(8'h13),
    .INTER_GAP(GAP),
    .BUSY_TMO (TMO)
  ) dut (
    .clk_uart       (clk_uart),
    .rst            (rst),
    .flow_en        (flow_en),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_rd_en     (fifo_rd_en),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .remote_xoff_lvl(remote_xoff_lvl),
    .local_pause_lvl(local_pause_lvl),
    .xoff_sent      (xoff_sent),
    .sched_idle     (sched_idle),
    .tmo_err        (tmo_err),
    .data_cnt       (data_cnt),
    .ctl_cnt        (ctl_cnt)
  );

  // FIFO model: registered read data, valid the cycle after fifo_rd_en
  logic [7:0] mem [256];
  int wr_n = 0;
  int rd_n = 0;
  assign fifo_empty = (wr_n == rd_n);
  always @(posedge clk_uart) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_n[7:0]];
      rd_n <= rd_n + 1;
    end
  end

  // Serializer model: busy for busy_len cycles after tx_start; 0 = never
  int busy_len = 10;
  int bcnt;
  always @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      bcnt <= 0;
    end else if (tx_start && busy_len > 0) begin
      tx_busy <= 1'b1;
      bcnt <= busy_len;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt <= 0;
      tx_busy <= 1'b0;
    end
  end

  // Monitor: log every start, timeout and busy fall by cycle
  int cyc = 0;
  always @(posedge clk_uart) cyc <= cyc + 1;

  logic [7:0] sq [$];
  int stc [$];
  int sg [$];
  int tq [$];
  int last_fall = 0;
  int rd_pulses = 0;
  int uf_cnt = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk_uart) begin
    if (busy_prev && !tx_busy) last_fall = cyc;
    busy_prev = tx_busy;
    if (tx_start) begin
      sq.push_back(tx_data);
      stc.push_back(cyc);
      sg.push_back(cyc - last_fall);
    end
    if (fifo_rd_en) begin
      rd_pulses++;
      if (fifo_empty) uf_cnt++;
    end
    if (tmo_err) tq.push_back(cyc);
  end

  int n_chk = 0;
  int n_fail = 0;
  int sp = 0;
  int exp_dc = 0;
  int exp_cc = 0;
  int exp_tmo = 0;

  function automatic logic [15:0] dc(input int n);
`ifdef UART_TX_SCHED_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'(n) & 16'h0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_uart);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_n[7:0]] = b;
    wr_n++;
  endtask

  task automatic expect_start(input string nm, input logic [7:0] b);
    int k;
    k = 0;
    while (sq.size() <= sp && k < 80) begin
      tick(1);
      k++;
    end
    if (sq.size() <= sp) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no tx_start in 80 cycles, want %0h", nm, b);
    end else begin
      chk(nm, 32'(sq[sp]), 32'(b));
      sp++;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (sched_idle !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(sched_idle), 32'd1);
  endtask

  typedef struct {
    logic [7:0] b;
    int         blen;
    int         lat;
    bit         tmo;
  } vec_t;

  vec_t tbl [5];
  int t0;
  int rd0;
  int k;
  bit to;
  bit rp;
  logic [7:0] bs [3];

  initial begin
    tbl[0] = '{b: 8'hA5, blen: 10, lat: 3, tmo: 1'b0};
    tbl[1] = '{b: 8'h3C, blen: 10, lat: 3, tmo: 1'b0};
    tbl[2] = '{b: 8'h00, blen: 1,  lat: 3, tmo: 1'b0};
    tbl[3] = '{b: 8'hFF, blen: 3,  lat: 3, tmo: 1'b0};
    tbl[4] = '{b: 8'h5A, blen: 0,  lat: 3, tmo: 1'b1};

    tick(3);
    chk("rst_idle", 32'(sched_idle), 32'd1);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_xoff", 32'(xoff_sent), 32'd0);
    chk("rst_tmo", 32'(tmo_err), 32'd0);
    chk("rst_dcnt", 32'(data_cnt), 32'd0);
    chk("rst_ccnt", 32'(ctl_cnt), 32'd0);
    rst = 1'b1;
    tick(3);

    // Data path vectors, flow control disabled
    rd0 = rd_pulses;
    for (int i = 0; i < 5; i++) begin
      busy_len = tbl[i].blen;
      wait_idle("t1_pre_idle");
      push(tbl[i].b);
      t0 = cyc;
      expect_start($sformatf("t1_data%0d", i), tbl[i].b);
      chk("t1_lat", 32'(stc[sp-1] - t0), 32'(tbl[i].lat));
      if (tbl[i].tmo) begin
        tick(6);
        exp_tmo++;
        chk("t1_tmo_at", (tq.size() > 0) ?
            32'(tq[tq.size()-1] - stc[sp-1]) : 32'hFFFF, 32'(TMO));
      end else begin
        exp_dc++;
      end
      wait_idle("t1_post_idle");
      chk("t1_tmo_n", 32'(tq.size()), 32'(exp_tmo));
      chk("t1_rd_n", 32'(rd_pulses), 32'(rd0 + i + 1));
      chk("t1_dcnt", 32'(data_cnt), 32'(dc(exp_dc)));
    end

    // Pause raised mid-frame: XOFF overtakes queued data
    flow_en = 1'b1;
    busy_len = 10;
    tick(2);
    wait_idle("t2_pre_idle");
    push(8'h41);
    push(8'h42);
    expect_start("t2_b1", 8'h41);
    tick(2);
    local_pause_lvl = 1'b1;
    expect_start("t2_xoff", 8'h13);
    chk("t2_xoff_gap", 32'(sg[sp-1]), 32'(GAP + 2));
    expect_start("t2_b2", 8'h42);
    chk("t2_data_gap", 32'(sg[sp-1]), 32'(GAP + 4));
    chk("t2_xoff_sent", 32'(xoff_sent), 32'd1);
    exp_dc += 2;
    exp_cc++;
    chk("t2_ccnt", 32'(ctl_cnt), 32'(dc(exp_cc)));
    local_pause_lvl = 1'b0;
    expect_start("t2_xon", 8'h11);
    wait_idle("t2_idle");
    exp_cc++;
    chk("t2_xon_clear", 32'(xoff_sent), 32'd0);
    chk("t2_ccnt2", 32'(ctl_cnt), 32'(dc(exp_cc)));
    chk("t2_dcnt", 32'(data_cnt), 32'(dc(exp_dc)));

    // Remote pause holds data but not control characters
    remote_xoff_lvl = 1'b1;
    tick(4);
    rd0 = rd_pulses;
    push(8'h77);
    tick(15);
    chk("t3_hold_start", 32'(sq.size()), 32'(sp));
    chk("t3_hold_rd", 32'(rd_pulses), 32'(rd0));
    chk("t3_hold_idle", 32'(sched_idle), 32'd1);
    local_pause_lvl = 1'b1;
    expect_start("t3_xoff", 8'h13);
    wait_idle("t3_idle1");
    chk("t3_xoff_sent", 32'(xoff_sent), 32'd1);
    local_pause_lvl = 1'b0;
    expect_start("t3_xon", 8'h11);
    wait_idle("t3_idle2");
    chk("t3_xon_clear", 32'(xoff_sent), 32'd0);
    chk("t3_still_held", 32'(rd_pulses), 32'(rd0));
    exp_cc += 2;
    remote_xoff_lvl = 1'b0;
    expect_start("t3_resume", 8'h77);
    wait_idle("t3_idle3");
    exp_dc++;
    chk("t3_ccnt", 32'(ctl_cnt), 32'(dc(exp_cc)));

    // Pause pulse inside one frame: XON pending but redundant, dropped
    push(8'h99);
    expect_start("t4_data", 8'h99);
    tick(2);
    local_pause_lvl = 1'b1;
    tick(4);
    local_pause_lvl = 1'b0;
    wait_idle("t4_idle");
    tick(30);
    exp_dc++;
    chk("t4_no_ctl", 32'(sq.size()), 32'(sp));
    chk("t4_xoff_sent", 32'(xoff_sent), 32'd0);
    chk("t4_ccnt", 32'(ctl_cnt), 32'(dc(exp_cc)));
    chk("t4_dcnt", 32'(data_cnt), 32'(dc(exp_dc)));

    // flow_en dropped while paused: xoff_sent clears, no XON
    local_pause_lvl = 1'b1;
    expect_start("t5_xoff", 8'h13);
    wait_idle("t5_idle");
    exp_cc++;
    chk("t5_xoff_sent", 32'(xoff_sent), 32'd1);
    flow_en = 1'b0;
    tick(1);
    chk("t5_fe_clear", 32'(xoff_sent), 32'd0);
    local_pause_lvl = 1'b0;
    tick(20);
    flow_en = 1'b1;
    tick(20);
    chk("t5_no_xon", 32'(sq.size()), 32'(sp));
    chk("t5_ccnt", 32'(ctl_cnt), 32'(dc(exp_cc)));

    // Randomized bursts against the byte-stream model
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(1, 3);
      to = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0);
      busy_len = to ? 0 : $urandom_range(1, 8);
      wait_idle("rnd_pre_idle");
      if (rp) begin
        remote_xoff_lvl = 1'b1;
        tick(4);
      end
      for (int j = 0; j < k; j++) begin
        bs[j] = 8'($urandom);
        push(bs[j]);
      end
      if (rp) begin
        tick(15);
        chk("rnd_hold", 32'(sq.size()), 32'(sp));
        chk("rnd_hold_idle", 32'(sched_idle), 32'd1);
        remote_xoff_lvl = 1'b0;
      end
      for (int j = 0; j < k; j++) begin
        expect_start("rnd_data", bs[j]);
        if (to) exp_tmo++;
        else exp_dc++;
      end
      wait_idle("rnd_post_idle");
      chk("rnd_dcnt", 32'(data_cnt), 32'(dc(exp_dc)));
      chk("rnd_tmo_n", 32'(tq.size()), 32'(exp_tmo));
    end

    // Async reset during DRAIN: abort, no replay
    busy_len = 10;
    wait_idle("t6_pre_idle");
    push(8'hC3);
    expect_start("t6_data", 8'hC3);
    tick(4);
    rd0 = rd_pulses;
    rst = 1'b0;
    #1;
    chk("t6_rst_start", 32'(tx_start), 32'd0);
    chk("t6_rst_data", 32'(tx_data), 32'd0);
    chk("t6_rst_idle", 32'(sched_idle), 32'd1);
    chk("t6_rst_rd", 32'(fifo_rd_en), 32'd0);
    chk("t6_rst_tmo", 32'(tmo_err), 32'd0);
    chk("t6_rst_xoff", 32'(xoff_sent), 32'd0);
    chk("t6_rst_dcnt", 32'(data_cnt), 32'd0);
    chk("t6_rst_ccnt", 32'(ctl_cnt), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(40);
    chk("t6_no_replay", 32'(sq.size()), 32'(sp));
    chk("t6_no_read", 32'(rd_pulses), 32'(rd0));
    chk("t6_dcnt", 32'(data_cnt), 32'd0);
    chk("rd_underflow", 32'(uf_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout");
    $fatal(1, "watchdog");
  end

endmodule
